// File: rtl/minterm_sequencer_pkg.sv
// Shared types and defaults for the minterm sweep controller.
package minterm_pkg;

    localparam int unsigned DEFAULT_N = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/minterm_sequencer_settle_timer.sv
// Per-minterm settle counter: reloads to zero on load, flags the last settle cycle.
module settle_timer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired
);

    localparam int unsigned W = $clog2(SETTLE + 1);
    localparam logic [W-1:0] LAST = W'(SETTLE - 1);
    localparam logic [W-1:0] MAX  = W'(SETTLE);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Saturates at SETTLE so it idles harmlessly until the next load.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (cnt_q != MAX) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/minterm_sequencer.sv
// Walks all 2**N minterms through two implementations, captures both truth tables and grades them.
module minterm_sequencer
    import minterm_pkg::*;
#(
    parameter int unsigned N      = DEFAULT_N,
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2**N-1:0]   expect_tt,
    input  logic              f_a,
    input  logic              f_b,
    output logic [N-1:0]      x_out,
    output logic              busy,
    output logic              done,
    output logic [2**N-1:0]   truth,
    output logic [2**N-1:0]   mismatch,
    output logic              pass
);

    state_e            state_q, state_d;
    logic [N-1:0]      idx_q, idx_d;
    logic [2**N-1:0]   truth_q, truth_d;
    logic [2**N-1:0]   mismatch_q, mismatch_d;
    logic              pass_q, pass_d;
    logic [N-1:0]      x_out_q, x_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load;
    logic              expired;

    settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .expired (expired)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        truth_d    = truth_q;
        mismatch_d = mismatch_q;
        pass_d     = pass_q;
        load       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = APPLY;
                    idx_d      = '0;
                    truth_d    = '0;
                    mismatch_d = '0;
                    pass_d     = 1'b0;
                    load       = 1'b1;
                end
            end
            APPLY: begin
                if (expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                truth_d[idx_q]    = f_a;
                mismatch_d[idx_q] = f_a ^ f_b;
                // Grade on the way into DONE so pass is already valid alongside the done pulse.
                if (idx_q == '1) begin
                    state_d = DONE;
                    pass_d  = (mismatch_d == '0) && (truth_d == expect_tt);
                end else begin
                    state_d = APPLY;
                    idx_d   = idx_q + N'(1);
                    load    = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d == APPLY) || (state_d == SAMPLE);
        done_d  = (state_d == DONE);
        x_out_d = busy_d ? idx_d : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            truth_q    <= '0;
            mismatch_q <= '0;
            pass_q     <= 1'b0;
            x_out_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            truth_q    <= truth_d;
            mismatch_q <= mismatch_d;
            pass_q     <= pass_d;
            x_out_q    <= x_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign x_out    = x_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign truth    = truth_q;
    assign mismatch = mismatch_q;
    assign pass     = pass_q;

endmodule
